// File: rtl/zamanlayici_denetleyici_pkg.sv
// Shared definitions for the zamanlayici_denetleyici timer peripheral.
// Contents: register index encoding (byte offset bits [4:2]), CTRL/STATUS
// bit positions, COMPARE reset value, and a byte-lane merge helper used for
// partial (wb_sel_i) writes.
// The optional capture feature is enabled with `define ZAMANLAYICI_YAKALAMA_EN.

package zamanlayici_denetleyici_pkg;

    typedef enum logic [2:0] {
        REG_CTRL     = 3'd0,    // 0x00
        REG_PRESCALE = 3'd1,    // 0x04
        REG_COMPARE  = 3'd2,    // 0x08
        REG_COUNT    = 3'd3,    // 0x0C
        REG_STATUS   = 3'd4,    // 0x10
        REG_CAPTURE  = 3'd5     // 0x14, only with ZAMANLAYICI_YAKALAMA_EN
    } reg_idx_e;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_AUTO_BIT  = 1;
    localparam int CTRL_IRQ_BIT   = 2;

    localparam int STAT_MATCH_BIT = 0;
    localparam int STAT_CAP_BIT   = 1;

    localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

    // Replace only the byte lanes whose select bit is set.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = sel[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/zamanlayici_denetleyici_on_olcekleyici.sv
// on_olcekleyici: prescaler for the timer.
// Ports:
//   clk_i      system clock (rising edge)
//   rst_i      synchronous active-low reset
//   i_en       count enable; 0 holds the prescaler counter at 0
//   i_prescale terminal value; tick period is i_prescale+1 cycles
//   o_tick     one-cycle pulse on the cycle the counter reaches i_prescale

module on_olcekleyici #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  i_en,
    input  logic [PRESCALE_W-1:0] i_prescale,
    output logic                  o_tick
);

    logic [PRESCALE_W-1:0] r_pcnt;

    // >= rather than == so that lowering PRESCALE below the running count
    // ticks immediately instead of running the counter through a full wrap.
    assign o_tick = i_en && (r_pcnt >= i_prescale);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_pcnt <= '0;
        end else if (!i_en || o_tick) begin
            r_pcnt <= '0;
        end else begin
            r_pcnt <= r_pcnt + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/zamanlayici_denetleyici.sv
// zamanlayici_denetleyici: Wishbone slave timer peripheral.
// Prescaled 32-bit up-counter with compare match (sticky W1C flag), optional
// auto-reload and a level interrupt.
// Ports:
//   clk_i, rst_i            clock, synchronous active-low reset
//   wb_adr_i[5:0]           byte address, [4:2] selects the register
//   wb_dat_i, wb_we_i, wb_stb_i, wb_sel_i, wb_cyc_i   bus request
//   wb_ack_o, wb_dat_o      one-cycle ack, read data (0 when not acking)
//   yakala_i                capture input (only with ZAMANLAYICI_YAKALAMA_EN)
//   irq_o                   level interrupt
// Optional feature macro: ZAMANLAYICI_YAKALAMA_EN (capture register at 0x14).

module zamanlayici_denetleyici
    import zamanlayici_denetleyici_pkg::*;
#(
    parameter int PRESCALE_W = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [5:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
`ifdef ZAMANLAYICI_YAKALAMA_EN
    input  logic        yakala_i,
`endif
    output logic        irq_o
);

    logic                  r_ack;
    logic [31:0]           r_dat;
    logic                  r_en;
    logic                  r_auto;
    logic                  r_irq_en;
    logic [PRESCALE_W-1:0] r_prescale;
    logic [31:0]           r_compare;
    logic [31:0]           r_count;
    logic                  r_match;

    logic        w_acc;
    logic        w_wr;
    logic        w_map;
    reg_idx_e    w_idx;
    logic        w_wr_ctrl;
    logic        w_wr_pre;
    logic        w_wr_cmp;
    logic        w_wr_cnt;
    logic        w_wr_sts;
    logic        w_tick;
    logic        w_hit;
    logic        w_cap;
    logic [31:0] w_rdata;
    logic        w_unused;

    // A new access starts only when no ack is outstanding, so a held strobe
    // is served every second cycle.
    assign w_acc     = wb_cyc_i && wb_stb_i && !r_ack;
    assign w_wr      = w_acc && wb_we_i;
    assign w_map     = !wb_adr_i[5];
    assign w_idx     = reg_idx_e'(wb_adr_i[4:2]);
    assign w_wr_ctrl = w_wr && w_map && (w_idx == REG_CTRL);
    assign w_wr_pre  = w_wr && w_map && (w_idx == REG_PRESCALE);
    assign w_wr_cmp  = w_wr && w_map && (w_idx == REG_COMPARE);
    assign w_wr_cnt  = w_wr && w_map && (w_idx == REG_COUNT);
    assign w_wr_sts  = w_wr && w_map && (w_idx == REG_STATUS);
    assign w_unused  = &{1'b0, wb_adr_i[1:0]};

    on_olcekleyici #(.PRESCALE_W(PRESCALE_W)) u_on_olcekleyici (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_en       (r_en),
        .i_prescale (r_prescale),
        .o_tick     (w_tick)
    );

    assign w_hit = w_tick && (r_count == r_compare);

`ifdef ZAMANLAYICI_YAKALAMA_EN
    logic [2:0]  r_yak_sync;   // [1:0] synchroniser, [2] edge-detect history
    logic        r_cap;
    logic [31:0] r_capture;
    logic        w_cap_set;

    assign w_cap_set = r_yak_sync[1] && !r_yak_sync[2];
    assign w_cap     = r_cap;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_yak_sync <= '0;
            r_cap      <= 1'b0;
            r_capture  <= '0;
        end else begin
            r_yak_sync <= {r_yak_sync[1:0], yakala_i};
            if (w_cap_set) begin
                r_capture <= r_count;
                r_cap     <= 1'b1;
            end else if (w_wr_sts && wb_sel_i[0] && wb_dat_i[STAT_CAP_BIT]) begin
                r_cap <= 1'b0;
            end
        end
    end
`else
    assign w_cap = 1'b0;
`endif

    always_comb begin
        w_rdata = '0;
        if (w_map) begin
            case (w_idx)
                REG_CTRL:     w_rdata = {29'd0, r_irq_en, r_auto, r_en};
                REG_PRESCALE: w_rdata = 32'(r_prescale);
                REG_COMPARE:  w_rdata = r_compare;
                REG_COUNT:    w_rdata = r_count;
                REG_STATUS:   w_rdata = {30'd0, w_cap, r_match};
`ifdef ZAMANLAYICI_YAKALAMA_EN
                REG_CAPTURE:  w_rdata = r_capture;
`endif
                default:      w_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_ack      <= 1'b0;
            r_dat      <= '0;
            r_en       <= 1'b0;
            r_auto     <= 1'b0;
            r_irq_en   <= 1'b0;
            r_prescale <= '0;
            r_compare  <= COMPARE_RST;
            r_count    <= '0;
            r_match    <= 1'b0;
        end else begin
            r_ack <= w_acc;
            r_dat <= (w_acc && !wb_we_i) ? w_rdata : '0;

            // Software CTRL write takes priority over the match-stop.
            if (w_wr_ctrl && wb_sel_i[0]) begin
                r_en     <= wb_dat_i[CTRL_EN_BIT];
                r_auto   <= wb_dat_i[CTRL_AUTO_BIT];
                r_irq_en <= wb_dat_i[CTRL_IRQ_BIT];
            end else if (w_hit && !r_auto) begin
                r_en <= 1'b0;
            end

            if (w_wr_pre) begin
                r_prescale <= PRESCALE_W'(byte_merge(32'(r_prescale), wb_dat_i, wb_sel_i));
            end

            if (w_wr_cmp) begin
                r_compare <= byte_merge(r_compare, wb_dat_i, wb_sel_i);
            end

            if (w_wr_cnt) begin
                r_count <= byte_merge(r_count, wb_dat_i, wb_sel_i);
            end else if (w_tick) begin
                if (w_hit) begin
                    r_count <= r_auto ? 32'd0 : r_count;
                end else begin
                    r_count <= r_count + 32'd1;
                end
            end

            // Hardware set beats a simultaneous W1C.
            if (w_hit) begin
                r_match <= 1'b1;
            end else if (w_wr_sts && wb_sel_i[0] && wb_dat_i[STAT_MATCH_BIT]) begin
                r_match <= 1'b0;
            end
        end
    end

    assign wb_ack_o = r_ack;
    assign wb_dat_o = r_dat;
    assign irq_o    = r_irq_en && (r_match || w_cap);

endmodule

// File: tb/tb_zamanlayici_denetleyici.sv
module tb_zamanlayici_denetleyici;

    logic        clk_i    = 1'b0;
    logic        rst_i    = 1'b0;
    logic [5:0]  wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic        wb_we_i  = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic [3:0]  wb_sel_i = '0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_ack_o;
    logic [31:0] wb_dat_o;
    logic        irq_o;
`ifdef ZAMANLAYICI_YAKALAMA_EN
    logic        yakala_i = 1'b0;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int cyc_n  = 0;
    int t_ack_last = 0;

    localparam logic [5:0] A_CTRL = 6'h00, A_PRE = 6'h04, A_CMP = 6'h08,
                           A_CNT  = 6'h0C, A_STS = 6'h10, A_CAP = 6'h14;

    zamanlayici_denetleyici dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .wb_adr_i (wb_adr_i),
        .wb_dat_i (wb_dat_i),
        .wb_we_i  (wb_we_i),
        .wb_stb_i (wb_stb_i),
        .wb_sel_i (wb_sel_i),
        .wb_cyc_i (wb_cyc_i),
        .wb_ack_o (wb_ack_o),
        .wb_dat_o (wb_dat_o),
`ifdef ZAMANLAYICI_YAKALAMA_EN
        .yakala_i (yakala_i),
`endif
        .irq_o    (irq_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc_n <= cyc_n + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One single-word access; checks the ack shape on every transfer.
    task automatic bus(input logic we, input logic [5:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, output logic [31:0] rdat);
        @(negedge clk_i);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = sel;
        #1;
        chk("ack_before_edge", wb_ack_o, 0);
        @(posedge clk_i); #1;
        chk("ack_rise", wb_ack_o, 1);
        rdat = wb_dat_o;
        t_ack_last = cyc_n;
        @(negedge clk_i);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        @(posedge clk_i); #1;
        chk("ack_one_cycle", wb_ack_o, 0);
        chk("dat_idle_zero", wb_dat_o, 0);
    endtask

    task automatic wr(input logic [5:0] adr, input logic [31:0] dat, input logic [3:0] sel = 4'hF);
        logic [31:0] dummy;
        bus(1'b1, adr, dat, sel, dummy);
    endtask

    task automatic rd(input logic [5:0] adr, output logic [31:0] dat);
        bus(1'b0, adr, 32'h0, 4'h0, dat);
    endtask

    // Auto-reload counter value after n ticks starting from s, compare c.
    function automatic logic [31:0] auto_cnt(input longint s, input longint c, input longint n);
        if (n <= c - s) return 32'(s + n);
        return 32'((n - (c - s) - 1) % (c + 1));
    endfunction

    task automatic run_case(input int p, input logic [31:0] c, input logic [31:0] s, input logic auto_r);
        logic [31:0] d;
        logic [31:0] ticks;
        int t_en, t_irq;
        longint n;
        wr(A_CTRL, 32'h0);
        wr(A_PRE, 32'(p));
        wr(A_CMP, c);
        wr(A_CNT, s);
        wr(A_STS, 32'h1);
        chk("irq_idle", irq_o, 0);
        wr(A_CTRL, {29'd0, 1'b1, auto_r, 1'b1});
        t_en  = t_ack_last;
        ticks = c - s + 32'd1;
        t_irq = -1;
        for (int i = 0; i < 5000; i++) begin
            if (irq_o) begin
                t_irq = cyc_n;
                break;
            end
            @(posedge clk_i); #1;
        end
        chk("irq_delay", 32'(t_irq - t_en), ticks * 32'(p + 1));
        rd(A_STS, d);
        chk("status_match", d, 32'h1);
        if (auto_r) begin
            for (int k = 0; k < 3; k++) begin
                rd(A_CNT, d);
                n = longint'((t_ack_last - 1 - t_en) / (p + 1));
                chk("count_autoreload", d, auto_cnt(longint'(s), longint'(c), n));
                repeat (k + 3) @(posedge clk_i);
                #1;
            end
        end else begin
            rd(A_CNT, d);
            chk("count_stopped", d, c);
            rd(A_CTRL, d);
            chk("ctrl_en_cleared", d, 32'h4);
            wr(A_STS, 32'h1);
            chk("irq_after_w1c", irq_o, 0);
        end
    endtask

    initial begin
        logic [31:0] d;
        int p;
        logic [31:0] c, s;
        logic a;

        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_ack", wb_ack_o, 0);
        chk("rst_dat", wb_dat_o, 0);
        chk("rst_irq", irq_o, 0);
        @(negedge clk_i);
        rst_i = 1'b1;

        rd(A_CTRL, d); chk("rst_ctrl", d, 32'h0);
        rd(A_PRE, d);  chk("rst_prescale", d, 32'h0);
        rd(A_CMP, d);  chk("rst_compare", d, 32'hFFFF_FFFF);
        rd(A_CNT, d);  chk("rst_count", d, 32'h0);
        rd(A_STS, d);  chk("rst_status", d, 32'h0);

        run_case(3, 32'd5, 32'd0, 1'b1);
        run_case(3, 32'd5, 32'd0, 1'b0);

        wr(A_CTRL, 32'h0);
        wr(A_CNT, 32'h0);
        wr(A_CNT, 32'hAABB_CCDD, 4'b0101);
        rd(A_CNT, d);  chk("byte_enable", d, 32'h00BB_00DD);
        wr(6'h20, 32'hFFFF_FFFF);
        rd(6'h20, d);  chk("unmapped_read", d, 32'h0);
        rd(A_CTRL, d); chk("unmapped_no_alias", d, 32'h0);
        rd(A_CAP, d);  chk("capture_idle", d, 32'h0);
        wr(A_PRE, 32'h1234_5678);
        rd(A_PRE, d);  chk("prescale_width", d, 32'h0000_5678);

        run_case(0, 32'd7, 32'hFFFF_FFFF, 1'b0);

        for (int it = 0; it < 10; it++) begin
            p = int'($urandom_range(0, 7));
            c = $urandom_range(1, 20);
            s = $urandom_range(0, c);
            a = 1'($urandom_range(0, 1));
            run_case(p, c, s, a);
        end

        // Interrupt pending, then reset asserted while a read is being presented.
        wr(A_CTRL, 32'h0);
        wr(A_PRE, 32'h0);
        wr(A_CNT, 32'd3);
        wr(A_CMP, 32'd3);
        wr(A_CTRL, 32'h5);
        repeat (4) @(posedge clk_i);
        #1;
        chk("irq_before_reset", irq_o, 1);
        @(negedge clk_i);
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = A_CMP;
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        chk("reset_no_ack", wb_ack_o, 0);
        chk("reset_dat", wb_dat_o, 0);
        chk("reset_irq", irq_o, 0);
        @(negedge clk_i);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        chk("post_reset_no_ack", wb_ack_o, 0);
        rd(A_CMP, d);  chk("post_reset_compare", d, 32'hFFFF_FFFF);
        rd(A_CTRL, d); chk("post_reset_ctrl", d, 32'h0);
        rd(A_STS, d);  chk("post_reset_status", d, 32'h0);

`ifdef ZAMANLAYICI_YAKALAMA_EN
        wr(A_CNT, 32'd9);
        @(negedge clk_i);
        yakala_i = 1'b1;
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        yakala_i = 1'b0;
        rd(A_CAP, d);  chk("capture_value", d, 32'd9);
        rd(A_STS, d);  chk("capture_flag", d, 32'h2);
        wr(A_STS, 32'h2);
        rd(A_STS, d);  chk("capture_w1c", d, 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
